// File: rtl/jpeg_dequant_pkg.sv
// Shared widths and the JPEG zigzag-to-natural index map for the dequantiser.
package jpeg_defs;

  localparam int COEF_W  = 16;
  localparam int QUANT_W = 8;
  localparam int IDX_W   = 6;
  localparam int TBL_W   = 2;
  localparam int ADDR_W  = TBL_W + IDX_W;
  localparam int PROD_W  = COEF_W + QUANT_W + 1;

  // Entry k holds the row*8+col position of the k-th coefficient in zigzag order.
  localparam logic [IDX_W-1:0] DEZIGZAG [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [IDX_W-1:0] dezigzag(input logic [IDX_W-1:0] zz);
    return DEZIGZAG[zz];
  endfunction

endpackage

// File: rtl/jpeg_dequant_ram.sv
// Quantisation table store: 4 tables x 64 entries, one write port, one registered read port.
module jpeg_dequant_ram
  import jpeg_defs::*;
(
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [QUANT_W-1:0] wdata_i,
  input  logic               re_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [QUANT_W-1:0] rdata_o
);

  logic [QUANT_W-1:0] mem_q [2**ADDR_W];
  logic [QUANT_W-1:0] rdata_q;

  // A read colliding with a write to the same address returns the previous contents.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/jpeg_dequant.sv
// JPEG dequantise + de-zigzag, two-stage pipeline with a single backpressure-driven advance.
// JPEG_DEQUANT_SAT_EN: clamp the product to 16-bit signed range instead of wrapping.
module jpeg_dequant
  import jpeg_defs::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               img_start_i,
  input  logic               dqt_valid_i,
  input  logic [TBL_W-1:0]   dqt_table_i,
  input  logic [IDX_W-1:0]   dqt_idx_i,
  input  logic [QUANT_W-1:0] dqt_data_i,
  input  logic               inport_valid_i,
  input  logic [COEF_W-1:0]  inport_data_i,
  input  logic [IDX_W-1:0]   inport_idx_i,
  input  logic [TBL_W-1:0]   inport_table_i,
  input  logic               inport_eob_i,
  output logic               inport_accept_o,
  output logic               outport_valid_o,
  output logic [COEF_W-1:0]  outport_data_o,
  output logic [IDX_W-1:0]   outport_idx_o,
  output logic               outport_eob_o,
  input  logic               outport_accept_i
);

  logic               advance;
  logic               s1_valid_q;
  logic [COEF_W-1:0]  s1_data_q;
  logic [IDX_W-1:0]   s1_idx_q;
  logic               s1_eob_q;
  logic               out_valid_q;
  logic [COEF_W-1:0]  out_data_q;
  logic [IDX_W-1:0]   out_idx_q;
  logic               out_eob_q;
  logic [QUANT_W-1:0] quant;
  logic signed [PROD_W-1:0] coef_ext;
  logic signed [PROD_W-1:0] quant_ext;
  logic signed [PROD_W-1:0] prod;
  logic [COEF_W-1:0]  out_data_d;

  assign advance         = ~out_valid_q | outport_accept_i;
  assign inport_accept_o = advance;

  // Read address/enable freeze with the pipeline so the RAM output stays aligned with S1.
  jpeg_dequant_ram u_ram (
    .clk_i   (clk_i),
    .we_i    (dqt_valid_i),
    .waddr_i ({dqt_table_i, dqt_idx_i}),
    .wdata_i (dqt_data_i),
    .re_i    (advance & inport_valid_i),
    .raddr_i ({inport_table_i, inport_idx_i}),
    .rdata_o (quant)
  );

  assign coef_ext  = PROD_W'($signed(s1_data_q));
  assign quant_ext = $signed({{(PROD_W-QUANT_W){1'b0}}, quant});
  assign prod      = coef_ext * quant_ext;

  always_comb begin
    out_data_d = prod[COEF_W-1:0];
`ifdef JPEG_DEQUANT_SAT_EN
    if (prod > 25'sd32767) begin
      out_data_d = 16'h7FFF;
    end else if (prod < -25'sd32768) begin
      out_data_d = 16'h8000;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_idx_q    <= '0;
      s1_eob_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_eob_q   <= 1'b0;
    end else if (img_start_i) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (advance) begin
      s1_valid_q <= inport_valid_i;
      if (inport_valid_i) begin
        s1_data_q <= inport_data_i;
        s1_idx_q  <= dezigzag(inport_idx_i);
        s1_eob_q  <= inport_eob_i;
      end
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= out_data_d;
        out_idx_q  <= s1_idx_q;
        out_eob_q  <= s1_eob_q;
      end
    end
  end

  assign outport_valid_o = out_valid_q;
  assign outport_data_o  = out_data_q;
  assign outport_idx_o   = out_idx_q;
  assign outport_eob_o   = out_eob_q;

endmodule

// File: tb/tb_jpeg_dequant.sv
// Bench for jpeg_dequant: directed cases plus a randomized stream scored against a table/queue model.
module tb_jpeg_dequant;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        img_start_i = 1'b0;
  logic        dqt_valid_i = 1'b0;
  logic [1:0]  dqt_table_i = '0;
  logic [5:0]  dqt_idx_i = '0;
  logic [7:0]  dqt_data_i = '0;
  logic        inport_valid_i = 1'b0;
  logic [15:0] inport_data_i = '0;
  logic [5:0]  inport_idx_i = '0;
  logic [1:0]  inport_table_i = '0;
  logic        inport_eob_i = 1'b0;
  logic        inport_accept_o;
  logic        outport_valid_o;
  logic [15:0] outport_data_o;
  logic [5:0]  outport_idx_o;
  logic        outport_eob_o;
  logic        outport_accept_i = 1'b1;

  always #5 clk_i = ~clk_i;

  jpeg_dequant dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .img_start_i      (img_start_i),
    .dqt_valid_i      (dqt_valid_i),
    .dqt_table_i      (dqt_table_i),
    .dqt_idx_i        (dqt_idx_i),
    .dqt_data_i       (dqt_data_i),
    .inport_valid_i   (inport_valid_i),
    .inport_data_i    (inport_data_i),
    .inport_idx_i     (inport_idx_i),
    .inport_table_i   (inport_table_i),
    .inport_eob_i     (inport_eob_i),
    .inport_accept_o  (inport_accept_o),
    .outport_valid_o  (outport_valid_o),
    .outport_data_o   (outport_data_o),
    .outport_idx_o    (outport_idx_o),
    .outport_eob_o    (outport_eob_o),
    .outport_accept_i (outport_accept_i)
  );

  typedef struct {
    logic [15:0] data;
    logic [5:0]  idx;
    logic        eob;
  } beat_t;

  int    n_checks = 0;
  int    n_fails = 0;
  int    n_beats = 0;
  int    zz2nat [64];
  int    qtab [4][64];
  beat_t exp_q [$];
  logic  stall_prev = 1'b0;
  logic [23:0] held = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] reduce(input int coef, input int q);
    int p;
    p = coef * q;
`ifdef JPEG_DEQUANT_SAT_EN
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
`endif
    return 16'(p);
  endfunction

  // Zigzag order by walking the anti-diagonals of the 8x8 block.
  function automatic void build_zigzag();
    int r = 0;
    int c = 0;
    for (int k = 0; k < 64; k++) begin
      zz2nat[k] = r * 8 + c;
      if (((r + c) % 2) == 0) begin
        if (c == 7) r++;
        else if (r == 0) c++;
        else begin r--; c++; end
      end else begin
        if (r == 7) c++;
        else if (c == 0) r++;
        else begin r++; c--; end
      end
    end
  endfunction

  // Model and scoreboard, sampled mid-cycle while inputs and outputs are stable.
  always @(negedge clk_i) begin
    beat_t b;
    if (!rst_ni) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      check("accept_rule", 32'(inport_accept_o), 32'(!outport_valid_o || outport_accept_i));
      if (stall_prev)
        check("stall_hold", 32'({outport_valid_o, outport_eob_o, outport_idx_o, outport_data_o}), 32'(held));
      stall_prev = outport_valid_o && !outport_accept_i;
      held = {outport_valid_o, outport_eob_o, outport_idx_o, outport_data_o};
      if (outport_valid_o && outport_accept_i) begin
        check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          b = exp_q.pop_front();
          check("beat", 32'({outport_eob_o, outport_idx_o, outport_data_o}), 32'({b.eob, b.idx, b.data}));
        end
        n_beats++;
      end
      if (img_start_i) begin
        exp_q.delete();
        stall_prev = 1'b0;
      end else if (inport_valid_i && inport_accept_o) begin
        b.data = reduce(int'($signed(inport_data_i)), qtab[inport_table_i][inport_idx_i]);
        b.idx  = 6'(zz2nat[inport_idx_i]);
        b.eob  = inport_eob_i;
        exp_q.push_back(b);
      end
      if (dqt_valid_i) qtab[dqt_table_i][dqt_idx_i] = int'(dqt_data_i);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic dqt_write(input int t, input int i, input int v);
    dqt_valid_i = 1'b1;
    dqt_table_i = 2'(t);
    dqt_idx_i   = 6'(i);
    dqt_data_i  = 8'(v);
    tick();
    dqt_valid_i = 1'b0;
  endtask

  task automatic send_lat(input logic [15:0] d, input logic [5:0] zz, input logic [1:0] t,
                          input logic [15:0] exp_d, input logic [5:0] exp_i);
    int lat = 0;
    inport_valid_i   = 1'b1;
    inport_data_i    = d;
    inport_idx_i     = zz;
    inport_table_i   = t;
    inport_eob_i     = 1'b1;
    outport_accept_i = 1'b1;
    do begin
      tick();
      inport_valid_i = 1'b0;
      inport_eob_i   = 1'b0;
      lat++;
    end while (!outport_valid_o && lat < 10);
    check("latency", 32'(lat), 32'd2);
    check("lat_data", 32'(outport_data_o), 32'(exp_d));
    check("lat_idx", 32'(outport_idx_o), 32'(exp_i));
    tick();
    tick();
  endtask

  task automatic drain();
    int guard = 0;
    inport_valid_i   = 1'b0;
    outport_accept_i = 1'b1;
    while ((exp_q.size() > 0 || outport_valid_o) && guard < 20) begin
      tick();
      guard++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int k;
    int cyc;
    int beats0;
    logic acc;

    build_zigzag();
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_valid", 32'(outport_valid_o), 32'd0);
    check("rst_data", 32'(outport_data_o), 32'd0);
    check("rst_idx", 32'(outport_idx_o), 32'd0);
    check("rst_eob", 32'(outport_eob_o), 32'd0);
    check("rst_accept", 32'(inport_accept_o), 32'd1);
    #2 rst_ni = 1'b1;
    tick();

    for (int t = 0; t < 4; t++)
      for (int i = 0; i < 64; i++)
        dqt_write(t, i, (t == 0) ? 1 : int'($urandom_range(1, 255)));
    dqt_write(1, 3, 16);
    dqt_write(2, 5, 99);

    send_lat(16'd100, 6'd2, 2'd0, 16'd100, 6'd8);
    send_lat(16'hFFFB, 6'd3, 2'd1, 16'hFFB0, 6'd16);
`ifdef JPEG_DEQUANT_SAT_EN
    send_lat(16'd1000, 6'd5, 2'd2, 16'h7FFF, 6'd2);
`else
    send_lat(16'd1000, 6'd5, 2'd2, 16'h82B8, 6'd2);
`endif

    // Ten back-to-back coefficients, downstream stalls for five cycles, eob on the third.
    beats0 = n_beats;
    k = 0;
    cyc = 0;
    while (k < 10 && cyc < 100) begin
      inport_valid_i   = 1'b1;
      inport_data_i    = 16'(k * 7 + 1);
      inport_idx_i     = 6'(k);
      inport_table_i   = 2'd0;
      inport_eob_i     = (k == 2);
      outport_accept_i = !(cyc >= 4 && cyc < 9);
      @(negedge clk_i);
      acc = inport_accept_o;
      if (cyc >= 4 && cyc < 9) check("stall_accept_low", 32'(inport_accept_o), 32'd0);
      tick();
      if (acc) k++;
      cyc++;
    end
    inport_eob_i = 1'b0;
    drain();
    check("stream_beats", 32'(n_beats - beats0), 32'd10);

    // Flush with two beats in flight; the coefficient offered with img_start is dropped.
    inport_valid_i = 1'b1; inport_data_i = 16'd10; inport_idx_i = 6'd0; tick();
    inport_data_i = 16'd20; inport_idx_i = 6'd1; tick();
    inport_valid_i = 1'b0; outport_accept_i = 1'b0; tick();
    img_start_i = 1'b1; inport_valid_i = 1'b1; inport_data_i = 16'd30; tick();
    img_start_i = 1'b0; inport_valid_i = 1'b0;
    check("flush_valid", 32'(outport_valid_o), 32'd0);
    beats0 = n_beats;
    outport_accept_i = 1'b1;
    repeat (5) tick();
    check("flush_no_beats", 32'(n_beats - beats0), 32'd0);
    send_lat(16'd100, 6'd2, 2'd0, 16'd100, 6'd8);

    // Asynchronous reset mid-block clears valids; tables survive.
    inport_valid_i = 1'b1; inport_data_i = 16'd5; inport_idx_i = 6'd4; inport_table_i = 2'd0;
    tick();
    tick();
    inport_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1 check("async_rst_valid", 32'(outport_valid_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    send_lat(16'hFFFB, 6'd3, 2'd1, 16'hFFB0, 6'd16);

    for (int c = 0; c < 3000; c++) begin
      inport_valid_i   = ($urandom_range(0, 3) != 0);
      inport_data_i    = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 600)) - 300);
      inport_idx_i     = 6'($urandom_range(0, 63));
      inport_table_i   = 2'($urandom_range(0, 3));
      inport_eob_i     = ($urandom_range(0, 7) == 0);
      outport_accept_i = ($urandom_range(0, 3) != 0);
      dqt_valid_i      = ($urandom_range(0, 15) == 0);
      dqt_table_i      = 2'($urandom_range(0, 3));
      dqt_idx_i        = 6'($urandom_range(0, 63));
      dqt_data_i       = 8'($urandom_range(0, 255));
      img_start_i      = ($urandom_range(0, 199) == 0);
      tick();
    end
    dqt_valid_i  = 1'b0;
    img_start_i  = 1'b0;
    inport_eob_i = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
